deserializer: RTL and testbench
===============================

// Module: deserializer
// PURPOSE
//  Receive end of the serial packet link: samples a framed 1-bit stream on din
//  and rebuilds a 32-bit packet_t (field3..field0).
//  Presents each good packet on a bus.master port with a one-cycle data_en strobe.
//  Flags framing or parity faults on frame_err.
//  Sits at the sink side of the SERDES path, feeding the packet consumer logic.
// PARAMETERS
//  PKT_W      32  packet width in bits; must equal $bits(packet_t)
//  PARITY_EN  0   1: one even-parity bit follows the data bits; 0: no parity bit
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  din        in   1      serial line, idle low, sampled every clk
//  bus_m      mst  PKT_W+1  bus.master: data (packet_t) out, data_en (1) out
//  frame_err  out  1      one-cycle pulse: stop-bit or parity fault
//  busy       out  1      high while a frame is being received (state != IDLE)
// BEHAVIOUR
//  Frame format, one bit per clk, no gaps inside a frame:
//   - start '1'
//   - PKT_W data bits, LSB first (field0[0] first, field3[7] last)
//   - [parity bit if PARITY_EN]
//   - stop '0'
//  Back-to-back frames are legal: a new start bit may come in the cycle after a stop bit.
//  Reset: state=IDLE, bit_cnt=0, shift_reg=0, data='{0,0,0,0}, data_en=0,
//   frame_err=0, busy=0.
//  Reset mid-frame drops the partial packet and emits no strobe.
//  FSM (deser_state_t):
//   - IDLE: din==1 -> SHIFT with bit_cnt<=0; else stay.
//   - SHIFT: shift_reg <= {din, shift_reg[PKT_W-1:1]}; bit_cnt++.
//     When bit_cnt==PKT_W-1, go to PARITY if PARITY_EN, else STOP.
//   - PARITY: par_ok <= (din == ^shift_reg); -> STOP.
//   - STOP: din==0 && (par_ok || !PARITY_EN) -> good frame; otherwise bad frame.
//     Both cases -> IDLE.
//  Good frame:
//   - In the cycle after the stop bit is sampled, data <= shift_reg and data_en=1
//     for exactly 1 cycle.
//   - Field map: field0=[7:0], field1=[15:8], field2=[23:16], field3=[31:24].
//   - data holds its value until the next good frame.
//   - Latency: data_en comes 1 clk after the stop-bit sample, PKT_W+2(+1 parity)
//     clks after the start-bit sample.
//  Bad frame:
//   - frame_err=1 for 1 cycle, in the same timing slot as data_en would be.
//   - data_en stays 0 and data is unchanged.
//   - A stop bit of '1' is not taken as a new start bit; the receiver re-hunts from IDLE.
//  data_en and frame_err are never both high. Both are registered outputs.
//  bit_cnt is $clog2(PKT_W) bits wide; it saturates logic-free because the FSM leaves
//   SHIFT at PKT_W-1.
//  The line is taken as synchronous to clk; no oversampling or metastability sync
//   happens here.
// STRUCTURE
//  definitions pkg:
//   - packet_t (existing)
//   - typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} deser_state_t
//   - localparam START_BIT=1'b1, STOP_BIT=1'b0
//  Sub-module deser_shift_reg (shift-in register + bit counter, ports: clk, rst,
//   shift_en, din, q, last) is the natural split; the FSM and output regs stay
//   in deserializer.
// TESTING
//  1. rst, then frame 0xDEADBEEF (PARITY_EN=0)
//     -> 1 clk after stop: data_en=1,
//        data='{8'hDE, 8'hAD, 8'hBE, 8'hEF}.
//  2. Two back-to-back frames 0x00000001, then 0x80000000 with no idle gap
//     -> two data_en pulses 34 clks apart with the correct values; no frame_err.
//  3. Frame 0x12345678 with stop bit driven '1'
//     -> frame_err pulse; no data_en; data keeps its previous value; then a clean
//        frame is received.
//  4. PARITY_EN=1, frame 0xDEADBEEF: parity 0 -> data_en; parity 1 -> frame_err only.
//  5. rst asserted at data bit 10 of a frame, released, clean frame 0xA5A5A5A5 sent
//     -> outputs 0 during rst; no strobe for the aborted frame;
//        data_en with 0xA5A5A5A5.
//  6. din held 0 for 100 clks -> busy=0, data_en=0, frame_err=0 throughout.

Source files
------------

// File: rtl/deserializer_pkg.sv
`default_nettype none
// ============================================================
// deserializer_pkg : packet type, FSM states, framing constants
// Revision: 1.0
// ============================================================
package deserializer_pkg;

  typedef struct packed {
    logic [7:0] field3;
    logic [7:0] field2;
    logic [7:0] field1;
    logic [7:0] field0;
  } packet_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } deser_state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/bus.sv
`default_nettype none
// ============================================================
// bus : packet bus carrying a packet_t and its one-cycle strobe
// Revision: 1.0
// ============================================================
interface bus;
  import deserializer_pkg::*;

  packet_t data;
  logic    data_en;

  modport master (output data, output data_en);
  modport slave  (input  data, input  data_en);
endinterface
`default_nettype wire

// File: rtl/deser_shift_reg.sv
`default_nettype none
// ============================================================
// deser_shift_reg : LSB-first shift-in register with bit counter
// Revision: 1.0
// ============================================================
module deser_shift_reg #(
  parameter int PKT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             din,
  output logic [PKT_W-1:0] q,
  output logic             last
);
  localparam int CNT_W = $clog2(PKT_W);

  logic [CNT_W-1:0] bit_cnt;

  assign last = (bit_cnt == CNT_W'(PKT_W - 1));

  // The counter wraps on the last bit, so every frame starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      q       <= {din, q[PKT_W-1:1]};
      bit_cnt <= last ? '0 : bit_cnt + CNT_W'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================
// deserializer : framed serial receiver rebuilding packet_t words
// Revision: 1.0
// ============================================================
module deserializer
  import deserializer_pkg::*;
#(
  parameter int PKT_W     = 32,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  bus.master   bus_m,
  output logic frame_err,
  output logic busy
);
  deser_state_t     state, next_state;
  logic             shift_en;
  logic             last;
  logic             par_ok;
  logic             good_stb;
  logic             bad_stb;
  logic [PKT_W-1:0] shift_reg;

  deser_shift_reg #(.PKT_W(PKT_W)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .din      (din),
    .q        (shift_reg),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    good_stb   = 1'b0;
    bad_stb    = 1'b0;
    case (state)
      IDLE:   if (din == START_BIT) next_state = SHIFT;
      SHIFT: begin
        shift_en = 1'b1;
        if (last) next_state = PARITY_EN ? PARITY : STOP;
      end
      PARITY: next_state = STOP;
      STOP: begin
        // A '1' stop bit is rejected outright, never reused as a start bit.
        if (din == STOP_BIT && (par_ok || !PARITY_EN)) good_stb = 1'b1;
        else                                           bad_stb  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_ok        <= 1'b0;
      bus_m.data    <= '0;
      bus_m.data_en <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      if (state == PARITY) par_ok <= (din == ^shift_reg);
      if (good_stb) bus_m.data <= packet_t'(shift_reg);
      bus_m.data_en <= good_stb;
      frame_err     <= bad_stb;
    end
  end

  assign busy = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================
// tb_deserializer : scoreboard bench for both parity variants
// Revision: 1.0
// ============================================================
module tb_deserializer;
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic din0 = 1'b0;
  logic din1 = 1'b0;
  logic err0, err1, busy0, busy1;

  bus b0 ();
  bus b1 ();

  deserializer #(.PKT_W(32), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .din(din0), .bus_m(b0), .frame_err(err0), .busy(busy0)
  );
  deserializer #(.PKT_W(32), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .bus_m(b1), .frame_err(err1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last_good[2];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic score(input string tag, input bit have, input exp_t e,
                       input logic en, input logic er, input logic [31:0] d);
    check({tag, "_overlap"}, 64'(en && er), 64'd0);
    check({tag, "_expected"}, 64'(have), 64'd1);
    if (have) begin
      check({tag, "_kind"}, 64'(er), 64'(e.err));
      check({tag, "_data"}, 64'(d), 64'(e.data));
      check({tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   h;
    if (b0.data_en || err0) begin
      h = (q0.size() > 0);
      if (h) e = q0.pop_front();
      score("dut0", h, e, b0.data_en, err0, b0.data);
    end
    if (b1.data_en || err1) begin
      h = (q1.size() > 0);
      if (h) e = q1.pop_front();
      score("dut1", h, e, b1.data_en, err1, b1.data);
    end
  end

  task automatic drive(input int id, input logic b);
    @(negedge clk);
    if (id == 0) din0 = b;
    else         din1 = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din0 = 1'b0;
      din1 = 1'b0;
    end
  endtask

  // Strobe expected 34 negedges after the start bit is driven (35 with parity).
  task automatic send_frame(input int id, input logic [31:0] v, input logic par,
                            input logic stop, input bit good);
    exp_t e;
    drive(id, 1'b1);
    e.cyc  = cyc + 34 + id;
    e.err  = !good;
    e.data = good ? v : last_good[id];
    if (good) last_good[id] = v;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
    for (int i = 0; i < 32; i++) drive(id, v[i]);
    if (id == 1) drive(id, par);
    drive(id, stop);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_data0"}, 64'(b0.data), 64'd0);
    check({tag, "_en0"}, 64'(b0.data_en), 64'd0);
    check({tag, "_err0"}, 64'(err0), 64'd0);
    check({tag, "_busy0"}, 64'(busy0), 64'd0);
    check({tag, "_data1"}, 64'(b1.data), 64'd0);
    check({tag, "_en1"}, 64'(b1.data_en), 64'd0);
    check({tag, "_err1"}, 64'(err1), 64'd0);
    check({tag, "_busy1"}, 64'(busy1), 64'd0);
  endtask

  initial begin
    logic [31:0] abort_v;
    last_good[0] = '0;
    last_good[1] = '0;
    abort_v      = 32'hFFFF_0000;

    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;

    // 1: single frame and field map
    send_frame(0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    idle(3);
    check("t1_field3", 64'(b0.data.field3), 64'h DE);
    check("t1_field2", 64'(b0.data.field2), 64'h AD);
    check("t1_field1", 64'(b0.data.field1), 64'h BE);
    check("t1_field0", 64'(b0.data.field0), 64'h EF);

    // 2: back-to-back frames
    send_frame(0, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    send_frame(0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    idle(3);

    // 3: bad stop bit, then recovery
    send_frame(0, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    idle(3);
    check("t3_data_kept", 64'(b0.data), 64'h8000_0000);
    send_frame(0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
    idle(3);

    // 4: parity variant
    send_frame(1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    send_frame(1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    send_frame(1, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
    send_frame(1, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
    idle(3);
    check("t4_data_kept", 64'(b1.data), 64'h0000_0001);

    // 5: reset at data bit 10
    drive(0, 1'b1);
    for (int i = 0; i < 10; i++) drive(0, abort_v[i]);
    check("t5_busy_mid", 64'(busy0), 64'd1);
    @(negedge clk);
    rst  = 1'b1;
    din0 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_quiet("t5_rst");
    end
    rst = 1'b0;
    last_good[0] = '0;
    last_good[1] = '0;
    send_frame(0, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b1);
    idle(3);

    // 6: idle line
    repeat (100) begin
      @(negedge clk);
      din0 = 1'b0;
      check("t6_busy", 64'(busy0), 64'd0);
      check("t6_en", 64'(b0.data_en), 64'd0);
      check("t6_err", 64'(err0), 64'd0);
    end

    check("sb0_drained", 64'(q0.size()), 64'd0);
    check("sb1_drained", 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
